// File: rtl/seg_display_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_disp_pkg
// Brief    : Shared types and constants for the seven-segment display arbiter.
// Revision : 1.0
// ============================================================================
package seg_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FREE = 2'd2
    } state_t;

    localparam int         NUM_REQ  = 3;
    localparam logic [1:0] NO_OWNER = 2'd3;
    localparam int         DIGITS   = 4;
    localparam int         DATA_W   = 16;

    // Rotating successor of a requester index; valid for owner 0..2, step 1..2.
    function automatic logic [1:0] next_owner(input logic [1:0] owner,
                                              input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, owner} + {1'b0, step};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_display_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_arbiter_if
// Brief    : Valid/ready request bus from the display requesters to the arbiter.
// Revision : 1.0
// ============================================================================
interface seg_display_arbiter_if;
    import seg_disp_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );

endinterface
`default_nettype wire

// File: rtl/seg_display_arbiter_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_timer
// Brief    : Free-running digit scan: SCAN_DIV cycles per digit, four digits.
// Revision : 1.0
// ============================================================================
module seg_scan_timer
    import seg_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] o_digit_sel,
    output logic       o_tick
);

    localparam int SEL_W = $clog2(DIGITS);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [SEL_W-1:0] r_digit_sel;
    logic             w_tick;

    assign w_tick      = (r_div_cnt == c_DIV_LAST);
    assign o_tick      = w_tick;
    assign o_digit_sel = r_digit_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt   <= '0;
            r_digit_sel <= '0;
        end else if (w_tick) begin
            r_div_cnt   <= '0;
            r_digit_sel <= r_digit_sel + 1'b1;
        end else begin
            r_div_cnt   <= r_div_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_arbiter
// Brief    : Round-robin ownership of the 4-digit display with a minimum hold.
// Revision : 1.0
// ============================================================================
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_display_arbiter_if.slave  bus,
    output logic [1:0]            cur_owner,
    output logic [3:0]            digit,
    output logic [3:0]            seg_en
);

    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] c_HOLD_LOAD  = HOLD_W'(HOLD_CYCLES);
    localparam state_t            c_GRANT_ST   = (HOLD_CYCLES == 0) ? FREE : HOLD;

    state_t              r_state;
    logic [DATA_W-1:0]   r_value;
    logic [1:0]          r_owner;
    logic [HOLD_W-1:0]   r_hold_cnt;

    logic [NUM_REQ-1:0]  w_ready;
    logic                w_xfer;
    logic [1:0]          w_gnt_idx;
    logic [DATA_W-1:0]   w_gnt_data;
    logic [1:0]          w_next1;
    logic [1:0]          w_next2;
    logic [1:0]          w_sel;
    logic                w_scan_tick_unused;

    seg_scan_timer #(
        .SCAN_DIV    (SCAN_DIV)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .o_digit_sel (w_sel),
        .o_tick      (w_scan_tick_unused)
    );

    // Grant selection; non-owners take priority over an owner rewrite in FREE.
    always_comb begin
        w_ready = '0;
        w_next1 = next_owner(r_owner, 2'd1);
        w_next2 = next_owner(r_owner, 2'd2);
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid[0])      w_ready = 3'b001;
                    else if (bus.req_valid[1]) w_ready = 3'b010;
                    else if (bus.req_valid[2]) w_ready = 3'b100;
                end
                HOLD: begin
                    if (bus.req_valid[r_owner]) w_ready[r_owner] = 1'b1;
                end
                FREE: begin
                    if (bus.req_valid[w_next1])      w_ready[w_next1] = 1'b1;
                    else if (bus.req_valid[w_next2]) w_ready[w_next2] = 1'b1;
                    else if (bus.req_valid[r_owner]) w_ready[r_owner] = 1'b1;
                end
                default: w_ready = '0;
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign w_xfer        = |(bus.req_valid & w_ready);
    assign w_gnt_idx     = w_ready[2] ? 2'd2 : (w_ready[1] ? 2'd1 : 2'd0);

    always_comb begin
        case (w_gnt_idx)
            2'd1:    w_gnt_data = bus.req_data[31:16];
            2'd2:    w_gnt_data = bus.req_data[47:32];
            default: w_gnt_data = bus.req_data[15:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_value    <= '0;
            r_owner    <= NO_OWNER;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_value    <= w_gnt_data;
                        r_owner    <= w_gnt_idx;
                        r_hold_cnt <= c_HOLD_LOAD;
                        r_state    <= c_GRANT_ST;
                    end
                end
                HOLD: begin
                    // Owner rewrites update the value but never restart the hold.
                    if (w_xfer) r_value <= w_gnt_data;
                    if (r_hold_cnt <= HOLD_W'(1)) begin
                        r_hold_cnt <= '0;
                        r_state    <= FREE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end
                FREE: begin
                    if (w_xfer) begin
                        r_value <= w_gnt_data;
                        if (w_gnt_idx != r_owner) begin
                            r_owner    <= w_gnt_idx;
                            r_hold_cnt <= c_HOLD_LOAD;
                            r_state    <= c_GRANT_ST;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cur_owner = r_owner;
        seg_en    = 4'hF;
        digit     = 4'h0;
        if (r_state != IDLE) begin
            seg_en = ~(4'b0001 << w_sel);
            case (w_sel)
                2'd1:    digit = r_value[7:4];
                2'd2:    digit = r_value[11:8];
                2'd3:    digit = r_value[15:12];
                default: digit = r_value[3:0];
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_arbiter
// Brief    : Self-checking bench: request table, scoreboard, scan model.
// Revision : 1.0
// ============================================================================
module tb_seg_display_arbiter;

    localparam int SD = 4;
    localparam int HC = 10;

    typedef struct {
        int          due;
        logic [1:0]  owner;
        logic [15:0] value;
    } exp_t;

    typedef struct {
        int          pre;
        logic [2:0]  mask;
        logic [47:0] data;
        int          exp_idx;
        int          min_w;
        int          max_w;
    } row_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cur_owner;
    logic [3:0] digit;
    logic [3:0] seg_en;

    seg_display_arbiter_if bus();

    seg_display_arbiter #(
        .SCAN_DIV    (SD),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cur_owner (cur_owner),
        .digit     (digit),
        .seg_en    (seg_en)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          k     = 0;
    logic        exp_idle  = 1'b1;
    logic [1:0]  exp_owner = 2'd3;
    logic [15:0] exp_value = 16'h0;
    exp_t        sb[$];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] o, input logic [15:0] v);
        exp_t e;
        e.due   = cyc + 1;
        e.owner = o;
        e.value = v;
        sb.push_back(e);
    endtask

    // One clock: advance the scan model, retire due scoreboard entries, check display.
    task automatic cycle();
        logic        r;
        int          sel;
        logic [3:0]  es;
        logic [3:0]  ed;
        exp_t        e;
        r = rst;
        @(negedge clk);
        cyc++;
        if (r) begin
            k         = 0;
            exp_idle  = 1'b1;
            exp_owner = 2'd3;
            exp_value = 16'h0;
            sb.delete();
        end else begin
            k++;
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e         = sb.pop_front();
                exp_owner = e.owner;
                exp_value = e.value;
                exp_idle  = 1'b0;
            end
        end
        sel = (k / SD) % 4;
        es  = exp_idle ? 4'hF : ~(4'b0001 << sel);
        ed  = exp_idle ? 4'h0 : exp_value[4*sel +: 4];
        chk("seg_en", seg_en, es);
        chk("digit", digit, ed);
        chk("cur_owner", cur_owner, exp_owner);
        chk("ready_onehot", $countones(bus.req_ready) <= 1, 1);
    endtask

    task automatic offer(input row_t r);
        int         w;
        bit         got;
        logic [2:0] er;
        repeat (r.pre) cycle();
        bus.req_valid = r.mask;
        bus.req_data  = r.data;
        w   = 0;
        got = 1'b0;
        er  = 3'b001 << r.exp_idx;
        while (!got && w <= r.max_w + 2) begin
            #1;
            if (bus.req_ready != 3'b000) got = 1'b1;
            else begin
                cycle();
                w++;
            end
        end
        chk("grant_ready", bus.req_ready, er);
        chk("grant_wait", (w >= r.min_w && w <= r.max_w), 1);
        if (got) push(2'(r.exp_idx), r.data[16*r.exp_idx +: 16]);
        cycle();
        bus.req_valid = 3'b000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        row_t rows[6];
        row_t r6;
        logic [2:0] er;

        rows[0] = '{0,  3'b010, {16'h0000, 16'hCAFE, 16'h0000}, 1, 10, 10};
        rows[1] = '{HC, 3'b111, {16'hD00D, 16'hAAAA, 16'h0F0F}, 2, 0,  0};
        rows[2] = '{HC, 3'b100, {16'h9876, 16'h0000, 16'h0000}, 2, 0,  0};
        rows[3] = '{0,  3'b001, {16'h0000, 16'h0000, 16'h4321}, 0, 0,  0};
        rows[4] = '{0,  3'b110, {16'h7777, 16'h2468, 16'h0000}, 1, 10, 10};
        rows[5] = '{HC, 3'b011, {16'h0000, 16'h5555, 16'hFACE}, 0, 0,  0};
        r6      = '{0,  3'b010, {16'h0000, 16'hC0DE, 16'h0000}, 1, 0,  0};

        rst           = 1'b1;
        bus.req_valid = 3'b000;
        bus.req_data  = '0;

        // Reset for three cycles; a valid request must not see ready meanwhile.
        cycle();
        bus.req_valid = 3'b001;
        #1 chk("ready_in_reset", bus.req_ready, 0);
        cycle();
        bus.req_valid = 3'b000;
        cycle();
        rst = 1'b0;

        // Requester 1 from IDLE, owner rewrite mid-hold, requester 0 waits out the hold.
        bus.req_valid          = 3'b010;
        bus.req_data[31:16]    = 16'h1234;
        #1 chk("idle_grant", bus.req_ready, 3'b010);
        push(2'd1, 16'h1234);
        cycle();
        bus.req_valid = 3'b000;
        for (int j = 1; j <= HC; j++) begin
            cycle();
            if (j == 2) begin
                bus.req_valid[0]  = 1'b1;
                bus.req_data[15:0] = 16'hBEEF;
            end
            if (j == 3) begin
                bus.req_valid[1]   = 1'b1;
                bus.req_data[31:16] = 16'h5678;
            end
            if (j == 4) bus.req_valid[1] = 1'b0;
            #1;
            er = (j == 3) ? 3'b010 : ((j == HC) ? 3'b001 : 3'b000);
            chk("hold_ready", bus.req_ready, er);
            if (j == 3)  push(2'd1, 16'h5678);
            if (j == HC) push(2'd0, 16'hBEEF);
        end
        cycle();
        bus.req_valid = 3'b000;

        for (int i = 0; i < 6; i++) offer(rows[i]);

        // Reset in the middle of a hold while digit 2 is being scanned.
        repeat (HC) cycle();
        for (int t = 0; t < 16 && (k % 16) != 7; t++) cycle();
        offer(r6);
        cycle();
        rst           = 1'b1;
        bus.req_valid = 3'b100;
        #1 chk("ready_forced_low", bus.req_ready, 0);
        cycle();
        rst           = 1'b0;
        bus.req_valid = 3'b110;
        bus.req_data  = {16'h2222, 16'h1357, 16'h0000};
        #1 chk("post_reset_grant", bus.req_ready, 3'b010);
        push(2'd1, 16'h1357);
        cycle();
        bus.req_valid = 3'b000;
        repeat (20) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
